// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter for the lsu data RAM; define DMEM_ARB_RR_EN for round-robin ties, otherwise port 0 has fixed priority
module dmem_arbiter #(
    parameter int ADDR_W   = 11,
    parameter int LOCK_MAX = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_m0_req,
    input  logic              i_m0_we,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [31:0]       i_m0_wdata,
    input  logic [3:0]        i_m0_bmask,
    input  logic              i_m1_req,
    input  logic              i_m1_we,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [31:0]       i_m1_wdata,
    input  logic [3:0]        i_m1_bmask,
    input  logic              i_m1_lock,
    output logic              o_m0_gnt,
    output logic              o_m1_gnt,
    output logic              o_m0_rvalid,
    output logic              o_m1_rvalid,
    output logic [31:0]       o_m0_rdata,
    output logic [31:0]       o_m1_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_bmask,
    input  logic [31:0]       i_mem_rdata
);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    typedef enum logic {LK_FREE, LK_HELD} lock_t;

    lock_t            lock_q, lock_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             last_q, last_d;
    logic             rd_pend_q, rd_pend_d;
    logic             rd_owner_q, rd_owner_d;
    logic             tie, lock_act, lock_full, tie_p1, win_we, release_lk;

    // Winner selection: a lone requester wins; ties go to the lock holder until its slot budget is spent
    always_comb begin
        tie       = i_m0_req && i_m1_req;
        lock_act  = (lock_q == LK_HELD) && i_m1_lock;
        lock_full = lock_cnt_q == CNT_W'(LOCK_MAX);
`ifdef DMEM_ARB_RR_EN
        tie_p1    = lock_act ? !lock_full : !last_q;
`else
        tie_p1    = lock_act && !lock_full;
`endif
        o_m0_gnt  = !i_reset && i_m0_req && !(tie && tie_p1);
        o_m1_gnt  = !i_reset && i_m1_req && !(tie && !tie_p1);
    end

    // RAM command driven straight from the winner, all zero when nobody is granted
    always_comb begin
        win_we      = o_m1_gnt ? i_m1_we : (o_m0_gnt && i_m0_we);
        o_mem_en    = o_m0_gnt || o_m1_gnt;
        o_mem_we    = win_we;
        o_mem_addr  = o_m1_gnt ? i_m1_addr : o_m0_gnt ? i_m0_addr : '0;
        o_mem_wdata = o_m1_gnt ? i_m1_wdata : o_m0_gnt ? i_m0_wdata : '0;
        o_mem_bmask = !win_we ? 4'h0 : o_m1_gnt ? i_m1_bmask : i_m0_bmask;
    end

    // Read return steered to the port that issued the read in the previous cycle
    always_comb begin
        o_m0_rvalid = !i_reset && rd_pend_q && !rd_owner_q;
        o_m1_rvalid = !i_reset && rd_pend_q && rd_owner_q;
        o_m0_rdata  = o_m0_rvalid ? i_mem_rdata : '0;
        o_m1_rdata  = o_m1_rvalid ? i_mem_rdata : '0;
    end

    // Next state: pending read tag, last winner, and lock ownership with its grant counter
    always_comb begin
        release_lk = !i_m1_req || !i_m1_lock || o_m0_gnt;
        rd_pend_d  = o_mem_en && !win_we;
        rd_owner_d = rd_pend_d ? o_m1_gnt : rd_owner_q;
        last_d     = o_m0_gnt ? 1'b0 : o_m1_gnt ? 1'b1 : last_q;
        lock_d     = release_lk ? LK_FREE : o_m1_gnt ? LK_HELD : lock_q;
        lock_cnt_d = release_lk ? '0 :
                     (o_m1_gnt && !lock_full) ? lock_cnt_q + CNT_W'(1) : lock_cnt_q;
    end

    // State registers; reset leaves last = 1 so port 0 wins the first tie
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            lock_q     <= LK_FREE;
            lock_cnt_q <= '0;
            last_q     <= 1'b1;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            lock_q     <= lock_d;
            lock_cnt_q <= lock_cnt_d;
            last_q     <= last_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed plan steps plus randomized traffic against a cycle-level reference model
module tb_dmem_arbiter;
    localparam int ADDR_W   = 11;
    localparam int LOCK_MAX = 8;
    localparam int DEPTH    = 2 ** ADDR_W;

    logic clk = 1'b0;
    logic rst;
    logic m0_req, m0_we, m1_req, m1_we, m1_lock;
    logic [ADDR_W-1:0] m0_addr, m1_addr, mem_addr;
    logic [31:0] m0_wdata, m1_wdata, rd0, rd1, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [3:0] m0_bmask, m1_bmask, mem_bmask;
    logic g0, g1, rv0, rv1, mem_en, mem_we;
    logic [31:0] ram [DEPTH];

    int tests = 0;
    int failed = 0;

    logic [31:0] gold [DEPTH];
    int last_port, streak, pend_port;
    bit pend_v;
    logic [31:0] pend_data;

    logic o_g0, o_g1, o_rv0, o_rv1;
    logic [31:0] o_rd0, o_rd1;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .LOCK_MAX(LOCK_MAX)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata), .i_m0_bmask(m0_bmask),
        .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata), .i_m1_bmask(m1_bmask),
        .i_m1_lock(m1_lock),
        .o_m0_gnt(g0), .o_m1_gnt(g1), .o_m0_rvalid(rv0), .o_m1_rvalid(rv1),
        .o_m0_rdata(rd0), .o_m1_rdata(rd1),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_bmask(mem_bmask), .i_mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= merge(ram[mem_addr], mem_wdata, mem_bmask);
            else mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_m0(input logic req, input logic we, input int addr, input logic [31:0] wd, input logic [3:0] bm);
        m0_req = req; m0_we = we; m0_addr = ADDR_W'(addr); m0_wdata = wd; m0_bmask = bm;
    endtask

    task automatic set_m1(input logic req, input logic we, input int addr, input logic [31:0] wd, input logic [3:0] bm, input logic lk);
        m1_req = req; m1_we = we; m1_addr = ADDR_W'(addr); m1_wdata = wd; m1_bmask = bm; m1_lock = lk;
    endtask

    task automatic idle();
        set_m0(0, 0, 0, 0, 0);
        set_m1(0, 0, 0, 0, 0, 0);
    endtask

    // One clock cycle: check every output against the model, then advance the model
    task automatic step();
        logic e0, e1, tie, p1w, ewe, erv0, erv1, locked;
        logic [ADDR_W-1:0] ea;
        logic [31:0] ew;
        logic [3:0] eb;
        @(negedge clk);
        tie = m0_req && m1_req;
        locked = streak > 0 && m1_lock;
`ifdef DMEM_ARB_RR_EN
        p1w = locked ? (streak < LOCK_MAX) : (last_port == 0);
`else
        p1w = locked && streak < LOCK_MAX;
`endif
        e0 = !rst && m0_req && !(tie && p1w);
        e1 = !rst && m1_req && !(tie && !p1w);
        ewe = e1 ? m1_we : (e0 && m0_we);
        ea = e1 ? m1_addr : e0 ? m0_addr : '0;
        ew = e1 ? m1_wdata : e0 ? m0_wdata : '0;
        eb = !ewe ? 4'h0 : e1 ? m1_bmask : m0_bmask;
        erv0 = !rst && pend_v && pend_port == 0;
        erv1 = !rst && pend_v && pend_port == 1;
        chk("gnt0", g0, e0);
        chk("gnt1", g1, e1);
        chk("mem_en", mem_en, e0 || e1);
        chk("mem_we", mem_we, ewe);
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ew);
        chk("mem_bmask", mem_bmask, eb);
        chk("rvalid0", rv0, erv0);
        chk("rvalid1", rv1, erv1);
        chk("rdata0", rd0, erv0 ? pend_data : 32'h0);
        chk("rdata1", rd1, erv1 ? pend_data : 32'h0);
        o_g0 = g0; o_g1 = g1; o_rv0 = rv0; o_rv1 = rv1; o_rd0 = rd0; o_rd1 = rd1;
        if (rst) begin
            last_port = 1; streak = 0; pend_v = 0;
        end else begin
            pend_v = (e0 || e1) && !ewe;
            pend_port = e1 ? 1 : 0;
            pend_data = gold[ea];
            if (ewe) gold[ea] = merge(gold[ea], ew, eb);
            if (e0) last_port = 0;
            else if (e1) last_port = 1;
            if (!m1_req || !m1_lock || e0) streak = 0;
            else if (e1 && streak < LOCK_MAX) streak++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] gseq;
        logic [11:0] h0, h1;
        bit m0_done;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = '0;
            gold[i] = '0;
        end
        last_port = 1; streak = 0; pend_v = 0; pend_port = 0; pend_data = '0;
        rst = 1;
        set_m0(1, 0, 4, 32'h1, 4'hF);
        set_m1(1, 1, 6, 32'h2, 4'hF, 1);
        step();
        step();
        chk("reset_gnt0", o_g0, 0);
        chk("reset_rv1", o_rv1, 0);

        // read pending when reset hits
        rst = 0; idle();
        set_m0(1, 0, 'h010, 0, 0);
        step();
        rst = 1; idle();
        set_m1(1, 0, 'h011, 0, 0, 0);
        step();
        chk("rst_pend_rv0", o_rv0, 0);
        chk("rst_pend_rd0", o_rd0, 0);
        step();
        rst = 0; idle();
        step();
        chk("post_rst_rv0", o_rv0, 0);

        // single master write then read
        set_m1(1, 1, 'h005, 32'hDEADBEEF, 4'hF, 0);
        step();
        chk("single_wr_gnt1", o_g1, 1);
        set_m1(1, 0, 'h005, 0, 0, 0);
        step();
        chk("single_rd_gnt1", o_g1, 1);
        idle();
        step();
        chk("single_rv1", o_rv1, 1);
        chk("single_rd1", o_rd1, 32'hDEADBEEF);
        chk("single_rv0", o_rv0, 0);

        // byte-mask merge
        set_m0(1, 1, 'h003, 32'h11223344, 4'hF);
        step();
        set_m0(1, 1, 'h003, 32'hAABBCCDD, 4'h2);
        step();
        set_m0(1, 0, 'h003, 0, 0);
        step();
        idle();
        step();
        chk("bmask_rd0", o_rd0, 32'h1122CC44);

        // continuous tie from a fresh reset
        rst = 1; step(); rst = 0;
        set_m0(1, 0, 'h001, 0, 0);
        set_m1(1, 0, 'h002, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            gseq[i] = o_g0;
        end
        idle();
        step();
`ifdef DMEM_ARB_RR_EN
        chk("tie_seq", gseq, 4'b0101);
`else
        chk("tie_seq", gseq, 4'b1111);
`endif

        // lock bound: port 1 engages alone, port 0 joins and holds until served
        set_m1(1, 0, 'h007, 0, 0, 1);
        m0_done = 0;
        for (int k = 0; k < 12; k++) begin
            if (k >= 1 && !m0_done) set_m0(1, 0, 'h008, 0, 0);
            else set_m0(0, 0, 0, 0, 0);
            step();
            h0[k] = o_g0;
            h1[k] = o_g1;
            if (o_g0) m0_done = 1;
        end
        idle();
        step();
        chk("lock_p1_run", h1[7:0], 8'hFF);
        chk("lock_p0_grants", h0, 12'h100);
        chk("lock_p1_resume", h1[11:9], 3'b111);

        // back-to-back reads from different ports
        set_m0(1, 1, 'h001, 32'hA5A50001, 4'hF);
        step();
        set_m0(0, 0, 0, 0, 0);
        set_m1(1, 1, 'h002, 32'h5A5A0002, 4'hF, 0);
        step();
        set_m1(0, 0, 0, 0, 0, 0);
        set_m0(1, 0, 'h001, 0, 0);
        step();
        set_m0(0, 0, 0, 0, 0);
        set_m1(1, 0, 'h002, 0, 0, 0);
        step();
        chk("b2b_rv0", o_rv0, 1);
        chk("b2b_rd0", o_rd0, 32'hA5A50001);
        chk("b2b_rv1_n1", o_rv1, 0);
        idle();
        step();
        chk("b2b_rv1", o_rv1, 1);
        chk("b2b_rd1", o_rd1, 32'h5A5A0002);
        chk("b2b_rv0_n2", o_rv0, 0);

        // randomized traffic; a request stays put until granted
        o_g0 = 0; o_g1 = 0;
        for (int c = 0; c < 800; c++) begin
            rst = $urandom_range(0, 59) == 0;
            if (!m0_req || o_g0 || rst)
                set_m0($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom, 4'($urandom));
            if (!m1_req || o_g1 || rst)
                set_m1($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom, 4'($urandom), $urandom_range(0, 5) != 0);
            step();
        end
        rst = 0; idle();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
